eq_coeff_bank: RTL and testbench
================================

Name: eq_coeff_bank

Overview:
- Double-buffered coefficient store that answers the equalizer's coefficient read port: equalizer drives eq_coeff_addr, this block returns eq_coeff one clock later.
- A host/control path streams a complete new coefficient set into the shadow bank. The banks swap only on a sample-frame boundary, so the equalizer never mixes coefficients of two sets within one sample.
- Sits between the control/register path and the equalizer; replaces bench-side coefficient RAM selection.

Parameters:
- NR_CHANNELS, 3, audio channels served by the equalizer
- NR_EQ_BANDS, 8, biquad bands per channel
- EQ_COEFF_WIDTH, 32, coefficient width; fixed point with 3 integer bits, unity = 1 << (EQ_COEFF_WIDTH-4)
- NR_EQ_BAND_COEFF, 5, coefficients per band: A0, A1, A2, -B1, -B2 (localparam)
- NR_EQ_COEFF, NR_CHANNELS*NR_EQ_BANDS*NR_EQ_BAND_COEFF, derived, total words per bank (localparam)
- EQ_COEFF_ADDR_WIDTH, $clog2(NR_EQ_COEFF), derived (localparam)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- eq_coeff_addr  in  EQ_COEFF_ADDR_WIDTH  read address from equalizer
- eq_coeff  out  EQ_COEFF_WIDTH  coefficient at last cycle's address
- frame_sync  in  1  one-cycle pulse at sample-frame boundary (equalizer input accepted with s_tid==0)
- c_tdata  in  EQ_COEFF_WIDTH  coefficient load data, address order 0..NR_EQ_COEFF-1
- c_tvalid  in  1  load data valid
- c_tlast  in  1  marks last word of a set
- c_tready  out  1  load data accepted when c_tvalid & c_tready
- bank_sel  out  1  index of active bank
- swap_pending  out  1  full set loaded, waiting for frame_sync
- load_error  out  1  sticky; set on a wrong-length set

Behaviour:
Reset (rst_n=0 at posedge):
- state=LOAD, write pointer=0, bank_sel=0, swap_pending=0, load_error=0, c_tready=0 during reset, eq_coeff=0, use_default=1.
- RAM contents are not reset.

Read path:
- eq_coeff registered, latency exactly 1 clock; reads occur every cycle regardless of load activity.
- While use_default=1: eq_coeff = unity when (addr % NR_EQ_BAND_COEFF)==0, else 0 (pass-through EQ).
- Address >= NR_EQ_COEFF returns 0.

Load path, states:
- LOAD: c_tready=1. Each accepted word is written to bank ~bank_sel at the write pointer; pointer increments.
  - c_tlast with pointer==NR_EQ_COEFF-1 -> PENDING.
  - c_tlast early, or word accepted at pointer==NR_EQ_COEFF-1 without c_tlast -> load_error=1, pointer=0, stay in LOAD; the partial set is discarded and no swap occurs.
  - Words after an error are treated as the start of a new set.
- PENDING: c_tready=0, swap_pending=1. On frame_sync: bank_sel toggles, use_default=0, pointer=0 -> LOAD. The swap takes effect for reads addressed in the same cycle as frame_sync; eq_coeff reflects the new bank the following cycle.
- frame_sync in LOAD is ignored.
- Reset mid-load discards the set; bank_sel returns to 0 and use_default=1.

Misc:
- load_error clears only on reset.
- Reads and writes never target the same bank, so no read-during-write hazard exists.

Decomposition:
- Package eq_pkg holds NR_EQ_BAND_COEFF, the unity-coefficient constant function and the state enum {LOAD, PENDING}; shared with the equalizer.
- One sub-module, eq_coeff_dpram: simple dual-port RAM, one write port, one registered read port, NR_EQ_COEFF words. Instantiate it twice, or once with the bank bit as the address MSB.

Test Plan:
- After reset, read addresses 0,1,5,119 -> eq_coeff = 0x10000000, 0, 0x10000000, 0 (1-cycle latency); bank_sel=0.
- Stream 120 words (value = index), tlast on word 119 -> swap_pending=1, c_tready=0. Pulse frame_sync -> bank_sel=1; read addr 7 -> 7 next cycle.
- Second set (value = index+1000) loaded while reads run continuously -> reads return old values until frame_sync, then index+1000, with no mixed frame.
- tlast on word 50 -> load_error=1, no swap, bank_sel unchanged; a following correct 120-word set still swaps normally.
- 121 words without tlast at word 119 -> load_error=1 at word 119, nothing committed.
- rst_n low mid-load (word 60) -> default unity outputs, bank_sel=0, pointer=0, swap_pending=0.

Source files
------------

// File: rtl/eq_pkg.sv
// +----------------------------------------------------------------------------+
// | eq_pkg                                                                     |
// | Shared equalizer coefficient constants, load-state enum and unity helper.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package eq_pkg;

    localparam int NR_EQ_BAND_COEFF = 5;

    typedef enum logic [0:0] {
        LOAD    = 1'b0,
        PENDING = 1'b1
    } load_state_e;

    // Three integer bits plus sign: unity sits four bits below the MSB.
    function automatic logic [63:0] eq_unity(input int width);
        return 64'd1 << (width - 4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/eq_coeff_bank_if.sv
// +----------------------------------------------------------------------------+
// | eq_coeff_bank_if                                                           |
// | Coefficient read port, coefficient load stream and bank status signals.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface eq_coeff_bank_if
    import eq_pkg::*;
#(
    parameter int NR_CHANNELS    = 3,
    parameter int NR_EQ_BANDS    = 8,
    parameter int EQ_COEFF_WIDTH = 32
);

    localparam int NR_EQ_COEFF         = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF;
    localparam int EQ_COEFF_ADDR_WIDTH = $clog2(NR_EQ_COEFF);

    logic [EQ_COEFF_ADDR_WIDTH-1:0] eq_coeff_addr;
    logic [EQ_COEFF_WIDTH-1:0]      eq_coeff;
    logic                           frame_sync;
    logic [EQ_COEFF_WIDTH-1:0]      c_tdata;
    logic                           c_tvalid;
    logic                           c_tlast;
    logic                           c_tready;
    logic                           bank_sel;
    logic                           swap_pending;
    logic                           load_error;

    modport master (
        output eq_coeff_addr, frame_sync, c_tdata, c_tvalid, c_tlast,
        input  eq_coeff, c_tready, bank_sel, swap_pending, load_error
    );

    modport slave (
        input  eq_coeff_addr, frame_sync, c_tdata, c_tvalid, c_tlast,
        output eq_coeff, c_tready, bank_sel, swap_pending, load_error
    );

endinterface

`default_nettype wire

// File: rtl/eq_coeff_dpram.sv
// +----------------------------------------------------------------------------+
// | eq_coeff_dpram                                                             |
// | Simple dual-port RAM: one write port, one registered read port.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module eq_coeff_dpram #(
    parameter int DEPTH      = 120,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]      i_wdata,
    input  wire logic [ADDR_WIDTH-1:0] i_raddr,
    output logic      [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

`default_nettype wire

// File: rtl/eq_coeff_bank.sv
// +----------------------------------------------------------------------------+
// | eq_coeff_bank                                                              |
// | Double-buffered equalizer coefficient store, swapped on frame boundaries. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module eq_coeff_bank
    import eq_pkg::*;
#(
    parameter int NR_CHANNELS    = 3,
    parameter int NR_EQ_BANDS    = 8,
    parameter int EQ_COEFF_WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    eq_coeff_bank_if.slave  bus
);

    localparam int NR_EQ_COEFF         = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF;
    localparam int EQ_COEFF_ADDR_WIDTH = $clog2(NR_EQ_COEFF);
    localparam logic [EQ_COEFF_ADDR_WIDTH-1:0] LAST_ADDR  = EQ_COEFF_ADDR_WIDTH'(NR_EQ_COEFF - 1);
    localparam logic [EQ_COEFF_ADDR_WIDTH-1:0] BAND_WORDS = EQ_COEFF_ADDR_WIDTH'(NR_EQ_BAND_COEFF);
    localparam logic [EQ_COEFF_WIDTH-1:0]      UNITY      = EQ_COEFF_WIDTH'(eq_unity(EQ_COEFF_WIDTH));

    load_state_e                    r_state, w_state_nxt;
    logic [EQ_COEFF_ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic                           r_bank_sel, w_bank_sel_nxt;
    logic                           r_use_default, w_use_default_nxt;
    logic                           r_load_error, w_load_error_nxt;
    logic                           w_tready;
    logic                           w_accept;
    logic                           w_swap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= LOAD;
            r_wr_ptr      <= '0;
            r_bank_sel    <= 1'b0;
            r_use_default <= 1'b1;
            r_load_error  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_bank_sel    <= w_bank_sel_nxt;
            r_use_default <= w_use_default_nxt;
            r_load_error  <= w_load_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_wr_ptr_nxt      = r_wr_ptr;
        w_bank_sel_nxt    = r_bank_sel;
        w_use_default_nxt = r_use_default;
        w_load_error_nxt  = r_load_error;
        w_tready          = 1'b0;
        w_swap            = 1'b0;
        case (r_state)
            LOAD: begin
                w_tready = rst_n;
                if (w_tready && bus.c_tvalid) begin
                    if (bus.c_tlast && (r_wr_ptr == LAST_ADDR)) begin
                        w_state_nxt = PENDING;
                    end else if (bus.c_tlast || (r_wr_ptr == LAST_ADDR)) begin
                        // Wrong-length set: drop it, next word opens a fresh set.
                        w_load_error_nxt = 1'b1;
                        w_wr_ptr_nxt     = '0;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    end
                end
            end
            PENDING: begin
                if (bus.frame_sync) begin
                    w_swap            = 1'b1;
                    w_bank_sel_nxt    = ~r_bank_sel;
                    w_use_default_nxt = 1'b0;
                    w_wr_ptr_nxt      = '0;
                    w_state_nxt       = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    assign w_accept = w_tready & bus.c_tvalid;

    // Read path: a swap already applies to the address presented with frame_sync.
    logic                      w_rd_bank;
    logic                      w_rd_default;
    logic                      r_rd_bank;
    logic                      r_rd_default;
    logic                      r_rd_unity;
    logic                      r_rd_zero;
    logic [EQ_COEFF_WIDTH-1:0] w_ram_q [2];

    assign w_rd_bank    = w_swap ? ~r_bank_sel : r_bank_sel;
    assign w_rd_default = r_use_default & ~w_swap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_bank    <= 1'b0;
            r_rd_default <= 1'b1;
            r_rd_unity   <= 1'b0;
            r_rd_zero    <= 1'b1;
        end else begin
            r_rd_bank    <= w_rd_bank;
            r_rd_default <= w_rd_default;
            r_rd_unity   <= ((bus.eq_coeff_addr % BAND_WORDS) == '0);
            r_rd_zero    <= (bus.eq_coeff_addr > LAST_ADDR);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        localparam logic BANK_ID = 1'(g);

        eq_coeff_dpram #(
            .DEPTH      (NR_EQ_COEFF),
            .WIDTH      (EQ_COEFF_WIDTH),
            .ADDR_WIDTH (EQ_COEFF_ADDR_WIDTH)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_accept && (r_bank_sel != BANK_ID)),
            .i_waddr (r_wr_ptr),
            .i_wdata (bus.c_tdata),
            .i_raddr (bus.eq_coeff_addr),
            .o_rdata (w_ram_q[g])
        );
    end

    always_comb begin
        bus.eq_coeff = '0;
        if (!r_rd_zero) begin
            if (r_rd_default) begin
                bus.eq_coeff = r_rd_unity ? UNITY : '0;
            end else begin
                bus.eq_coeff = w_ram_q[r_rd_bank];
            end
        end
    end

    assign bus.c_tready     = w_tready;
    assign bus.bank_sel     = r_bank_sel;
    assign bus.swap_pending = (r_state == PENDING);
    assign bus.load_error   = r_load_error;

endmodule

`default_nettype wire

// File: tb/tb_eq_coeff_bank.sv
// +----------------------------------------------------------------------------+
// | tb_eq_coeff_bank                                                           |
// | Randomized scoreboard bench for the double-buffered coefficient store.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_eq_coeff_bank;

    localparam int N     = 120;
    localparam int AW    = 7;
    localparam int W     = 32;
    localparam int BANDW = 5;
    localparam logic [W-1:0] UNITY = 32'h1000_0000;

    typedef struct {
        logic [W-1:0] coeff;
        logic         bank;
        logic         pend;
        logic         err;
        logic         rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eq_coeff_bank_if #(.NR_CHANNELS(3), .NR_EQ_BANDS(8), .EQ_COEFF_WIDTH(W)) bus ();

    eq_coeff_bank #(.NR_CHANNELS(3), .NR_EQ_BANDS(8), .EQ_COEFF_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: the visible set, the last complete set and the set in flight.
    logic [W-1:0] m_active [N];
    logic [W-1:0] m_staged [N];
    logic [W-1:0] m_cur [$];
    bit           m_bank, m_def, m_pend, m_err;

    function automatic logic [W-1:0] model_read(input int addr);
        if (addr >= N)  return '0;
        if (m_def)      return ((addr % BANDW) == 0) ? UNITY : '0;
        return m_active[addr];
    endfunction

    task automatic step(input bit rst, input int addr, input bit fs, input bit vld,
                        input int data, input bit last, output bit accepted);
        exp_t e;
        bit   was_pend;
        @(negedge clk);
        rst_n             = !rst;
        bus.eq_coeff_addr = AW'(addr);
        bus.frame_sync    = fs;
        bus.c_tvalid      = vld;
        bus.c_tdata       = W'(data);
        bus.c_tlast       = last;
        accepted          = 1'b0;
        if (rst) begin
            m_bank = 0; m_def = 1; m_pend = 0; m_err = 0;
            m_cur.delete();
            e.coeff = '0;
        end else begin
            was_pend = m_pend;
            if (was_pend && fs) begin
                m_active = m_staged;
                m_bank   = !m_bank;
                m_def    = 0;
                m_pend   = 0;
            end
            e.coeff = model_read(addr);
            if (!was_pend && vld) begin
                accepted = 1'b1;
                m_cur.push_back(W'(data));
                if (last) begin
                    if (m_cur.size() == N) begin
                        for (int i = 0; i < N; i++) m_staged[i] = m_cur[i];
                        m_pend = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_cur.delete();
                end else if (m_cur.size() == N) begin
                    m_err = 1;
                    m_cur.delete();
                end
            end
        end
        e.bank = m_bank;
        e.pend = m_pend;
        e.err  = m_err;
        e.rdy  = !rst && !m_pend;
        q.push_back(e);
    endtask

    task automatic rd(input int addr);
        bit acc;
        step(0, addr, 0, 0, 0, 0, acc);
    endtask

    task automatic do_reset(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, acc);
    endtask

    // Random reads every cycle; stray valid words are offered only while a swap is pending.
    task automatic idle(input int n, input bit fs_at_end);
        bit acc;
        for (int i = 0; i < n; i++) begin
            step(0, int'($urandom_range(0, 127)), fs_at_end && (i == n - 1),
                 m_pend && ($urandom_range(0, 1) == 1), int'($urandom), 0, acc);
        end
    endtask

    task automatic load_set(input int n_words, input int base, input int last_at, input bit fs_mid);
        bit acc, vld;
        int sent = 0;
        int cyc  = 0;
        while (sent < n_words && cyc < 2000) begin
            vld = ($urandom_range(0, 3) != 0);
            step(0, int'($urandom_range(0, 127)), fs_mid && (sent == 30),
                 vld, base + sent, sent == last_at, acc);
            if (acc) sent++;
            cyc++;
        end
        n_cmp++;
        if (sent < n_words) begin
            n_err++;
            $display("FAIL load_set_timeout: accepted %0d words, required %0d", sent, n_words);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (bus.eq_coeff !== e.coeff || bus.bank_sel !== e.bank ||
                    bus.swap_pending !== e.pend || bus.load_error !== e.err ||
                    bus.c_tready !== e.rdy) begin
                    n_err++;
                    $display("FAIL cycle_check t=%0t: coeff %h req %h bank %b req %b pend %b req %b err %b req %b rdy %b req %b",
                             $time, bus.eq_coeff, e.coeff, bus.bank_sel, e.bank,
                             bus.swap_pending, e.pend, bus.load_error, e.err, bus.c_tready, e.rdy);
                end
            end
        end
    end

    initial begin : stimulus
        bit acc;
        bus.eq_coeff_addr = '0;
        bus.frame_sync    = 1'b0;
        bus.c_tvalid      = 1'b0;
        bus.c_tdata       = '0;
        bus.c_tlast       = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_active[i] = '0;
            m_staged[i] = '0;
        end

        do_reset(3);
        rd(0); rd(1); rd(5); rd(119); rd(120); rd(127);

        // First set, with a frame_sync in LOAD that must be ignored.
        load_set(N, 0, N - 1, 1);
        idle(6, 0);
        step(0, 7, 1, 0, 0, 0, acc);
        rd(7); rd(0); rd(119);
        idle(4, 0);

        // Second set while reads keep running.
        load_set(N, 1000, N - 1, 0);
        idle(4, 1);
        idle(8, 0);

        // Short set, then a good one.
        load_set(51, 3000, 50, 0);
        idle(3, 1);
        idle(3, 0);
        load_set(N, 2000, N - 1, 0);
        idle(3, 1);
        idle(6, 0);

        // Overlong set: error at word 119, nothing pending.
        load_set(121, 4000, -1, 0);
        idle(3, 1);
        idle(3, 0);

        // Reset mid-load.
        load_set(60, 5000, -1, 0);
        do_reset(2);
        rd(0); rd(1); rd(5); rd(7); rd(119);
        load_set(N, 6000, N - 1, 0);
        idle(3, 1);
        rd(7); rd(118);
        idle(6, 0);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
